// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and default widths for the L1-to-memory arbiter.
//   BLOCK_BITS_DEF : default cache block width (bits)
//   ADDR_BITS_DEF  : default byte-address width (bits)
//   arb_state_t    : arbiter FSM states
//   arb_src_t      : which cache-side channel owns the current transaction
package cache_pkg;

    localparam int BLOCK_BITS_DEF = 512;
    localparam int ADDR_BITS_DEF  = 32;

    // Byte-offset bits inside one 64-byte block; memory only sees block addresses.
    localparam int BLK_OFS_BITS   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_IC = 2'd0,
        SRC_DC = 2'd1,
        SRC_EV = 2'd2
    } arb_src_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin picker with a registered last-grant bit.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset (last grant -> req[0])
//   req     : request vector, req[0] and req[1]
//   update  : commit the current grant as the new last-grant
//   gnt     : one-hot grant (combinational from req and last-grant)
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 0: req[0] was granted last, 1: req[1] was granted last
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: hand it to whoever did not win last time.
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Serialises I-cache refills, D-cache refills and D-cache evicts onto one
// block-wide memory port, one transaction at a time.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   ic_request_i/ic_addr_i  : I-cache block read request (level, held until pulse)
//   ic_request_valid_o      : one-cycle refill-done pulse, with ic_addr_o/ic_data_o
//   dc_request_i/dc_addr_i  : D-cache block read request (level, held until pulse)
//   dc_request_valid_o      : one-cycle refill-done pulse, with dc_addr_o/dc_data_o
//   dc_evict_i/_addr_i/_data_i : D-cache write-back request (level, held until ack)
//   dc_evict_ack_o          : one-cycle evict-done pulse
//   mem_req_o/we/addr/wdata : memory transaction, held from GRANT through WAIT
//   mem_ready_i/mem_rdata_i : one-cycle completion from memory (+ read block)
//   err_o                   : sticky timeout flag
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int BLOCK_BITS = BLOCK_BITS_DEF,
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  ic_request_i,
    input  logic [ADDR_BITS-1:0]  ic_addr_i,
    output logic                  ic_request_valid_o,
    output logic [ADDR_BITS-1:0]  ic_addr_o,
    output logic [BLOCK_BITS-1:0] ic_data_o,

    input  logic                  dc_request_i,
    input  logic [ADDR_BITS-1:0]  dc_addr_i,
    output logic                  dc_request_valid_o,
    output logic [ADDR_BITS-1:0]  dc_addr_o,
    output logic [BLOCK_BITS-1:0] dc_data_o,

    input  logic                  dc_evict_i,
    input  logic [ADDR_BITS-1:0]  dc_evict_addr_i,
    input  logic [BLOCK_BITS-1:0] dc_evict_data_i,
    output logic                  dc_evict_ack_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,

    output logic                  err_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    // Clears the byte offset; a mask keeps every address bit in use.
    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'((1 << BLK_OFS_BITS) - 1);

    arb_state_t            state_q;
    arb_src_t              src_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [BLOCK_BITS-1:0] wdata_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [1:0]            rd_gnt;
    logic                  rd_upd;

    // Read choice between I (bit 0) and D (bit 1). An evict pre-empts the
    // read pick, and the round-robin history only moves on read grants.
    assign rd_upd = (state_q == IDLE) && !dc_evict_i;

    rr_arb2 u_rr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req     ({dc_request_i, ic_request_i}),
        .update  (rd_upd),
        .gnt     (rd_gnt)
    );

    assign cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q            <= IDLE;
            src_q              <= SRC_IC;
            addr_q             <= '0;
            wdata_q            <= '0;
            we_q               <= 1'b0;
            cnt_q              <= '0;
            mem_req_o          <= 1'b0;
            err_o              <= 1'b0;
            ic_request_valid_o <= 1'b0;
            ic_addr_o          <= '0;
            ic_data_o          <= '0;
            dc_request_valid_o <= 1'b0;
            dc_addr_o          <= '0;
            dc_data_o          <= '0;
            dc_evict_ack_o     <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle (the DONE cycle).
            ic_request_valid_o <= 1'b0;
            dc_request_valid_o <= 1'b0;
            dc_evict_ack_o     <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Evict goes first so the write-back lands before a
                    // refill of the same set.
                    if (dc_evict_i) begin
                        src_q     <= SRC_EV;
                        addr_q    <= dc_evict_addr_i & ALIGN_MASK;
                        wdata_q   <= dc_evict_data_i;
                        we_q      <= 1'b1;
                        mem_req_o <= 1'b1;
                        state_q   <= GRANT;
                    end else if (rd_gnt[1]) begin
                        src_q     <= SRC_DC;
                        addr_q    <= dc_addr_i & ALIGN_MASK;
                        we_q      <= 1'b0;
                        mem_req_o <= 1'b1;
                        state_q   <= GRANT;
                    end else if (rd_gnt[0]) begin
                        src_q     <= SRC_IC;
                        addr_q    <= ic_addr_i & ALIGN_MASK;
                        we_q      <= 1'b0;
                        mem_req_o <= 1'b1;
                        state_q   <= GRANT;
                    end
                end

                GRANT: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    cnt_q <= cnt_nxt;
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= DONE;
                        case (src_q)
                            SRC_IC: begin
                                ic_request_valid_o <= 1'b1;
                                ic_addr_o          <= addr_q;
                                ic_data_o          <= mem_rdata_i;
                            end
                            SRC_DC: begin
                                dc_request_valid_o <= 1'b1;
                                dc_addr_o          <= addr_q;
                                dc_data_o          <= mem_rdata_i;
                            end
                            default: dc_evict_ack_o <= 1'b1;
                        endcase
                    end else if (cnt_nxt >= CNT_LAST) begin
                        // Flag only; the transaction keeps waiting for memory.
                        err_o <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one higher-level memory port between the instruction-cache block-request channel and the data-cache request and evict channels.
- Serialises all traffic, one transaction at a time:
  - evicts: 512-bit block writes
  - refills: 512-bit block reads
- Returns completion pulses matching the cache-side handshakes (request_valid_i / evict_i).
- Sits between the L1 caches and the L2 / main-memory model.

Parameters:
- BLOCK_BITS, 512, cache block width in bits.
- ADDR_BITS, 32, byte-address width.
- TIMEOUT, 1024, maximum cycles to wait for mem_ready_i before flagging an error.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- ic_request_i  in  1  I-cache block read request, held until served
- ic_addr_i  in  ADDR_BITS  I-cache block address, 64B aligned
- ic_request_valid_o  out  1  one-cycle refill-done pulse to I-cache
- ic_addr_o  out  ADDR_BITS  address of returned block
- ic_data_o  out  BLOCK_BITS  returned block
- dc_request_i  in  1  D-cache block read request, held until served
- dc_addr_i  in  ADDR_BITS  D-cache refill address
- dc_request_valid_o  out  1  one-cycle refill-done pulse to D-cache
- dc_addr_o  out  ADDR_BITS  address of returned block
- dc_data_o  out  BLOCK_BITS  returned block
- dc_evict_i  in  1  D-cache evict/write-back request, held until acked
- dc_evict_addr_i  in  ADDR_BITS  evict address
- dc_evict_data_i  in  BLOCK_BITS  evict block
- dc_evict_ack_o  out  1  one-cycle evict-done pulse
- mem_req_o  out  1  memory transaction valid
- mem_we_o  out  1  1 = block write, 0 = block read
- mem_addr_o  out  ADDR_BITS  block address; bits [5:0] forced to 0
- mem_wdata_o  out  BLOCK_BITS  write block
- mem_ready_i  in  1  one-cycle completion pulse from memory
- mem_rdata_i  in  BLOCK_BITS  read block, valid when mem_ready_i
- err_o  out  1  sticky timeout flag

Behaviour:
- **Reset** (rst_n_i=0 at a clock edge):
  - state=IDLE, rr_last=I.
  - All outputs 0: data/addr buses, pulses, mem_req_o, err_o.
  - Reset mid-transaction drops mem_req_o the next cycle and issues no completion pulse; the requester re-requests.
- **State machine** (states IDLE, GRANT, WAIT, DONE):
  - IDLE: evaluate requests in priority order and latch the winner's id, addr, data and we into registers → GRANT. No request → stay in IDLE.
  - GRANT: mem_req_o=1, mem_* driven from the latched registers; clear the timeout counter → WAIT.
  - WAIT: mem_req_o stays 1 with stable fields.
    - mem_ready_i=1: latch mem_rdata_i → DONE.
    - Counter reaches TIMEOUT-1: set err_o; completion is not forced (stays in WAIT).
  - DONE: mem_req_o=0. Pulse exactly one of ic_request_valid_o / dc_request_valid_o / dc_evict_ack_o for one cycle → IDLE.
    - For reads, *_addr_o and *_data_o carry the latched block during the pulse. They hold that value afterwards until the next response to the same side.
- **Priority:**
  - dc_evict_i first, so the write-back is ordered ahead of the refill of the same set.
  - Then round-robin between dc_request_i and ic_request_i using rr_last; rr_last updates only on read grants.
- **Latency:** request seen in IDLE → mem_req_o high 2 cycles later (IDLE latch, GRANT). mem_ready_i → completion pulse 1 cycle later.
- **Min turnaround:** 4 cycles per transaction when memory answers in the cycle after GRANT.
- **Handshake rules:**
  - Requests are levels and must be held until their pulse.
  - Fields are sampled only in IDLE; changes after the grant are ignored.
  - A request deasserted before the grant is simply not served.
- **Spurious completions:** mem_ready_i outside WAIT is ignored.
- **Simultaneous events:**
  - All three requests asserted → evict, then the D/I read per rr_last, then the other read.
  - The requester pulsed in DONE may still show its request high in that cycle; IDLE re-evaluates the next cycle.
  - The caches drop the request combinationally on the pulse, so no double service occurs.
- **Widths:**
  - mem_addr_o = {addr[ADDR_BITS-1:6], 6'b0}.
  - Timeout counter is $clog2(TIMEOUT)+1 bits and saturates.
- **err_o:** sticky until reset.

Decomposition:
- cache_pkg holds:
  - BLOCK_BITS and ADDR_BITS defaults
  - typedef enum {IDLE, GRANT, WAIT, DONE} arb_state_t
  - typedef enum logic [1:0] {SRC_IC, SRC_DC, SRC_EV} arb_src_t
- One sub-module, rr_arb2: a 2-way round-robin picker (req[1:0], update, gnt[1:0], registered last-grant), instantiated for the I/D read choice.

Test Plan:
- **Single I refill:** ic_request_i=1, ic_addr_i=0x0000_1040; memory returns 512'hA5.. one cycle after GRANT → mem_addr_o=0x0000_1040, mem_we_o=0; ic_request_valid_o pulses once with ic_data_o=512'hA5..; dc outputs stay 0.
- **Evict priority:** dc_evict_i (addr 0x2000, data 512'h1234) and dc_request_i (addr 0x3000) asserted together → first transaction is we=1, addr 0x2000, wdata 512'h1234, ack pulse; then the read of 0x3000 and a dc_request_valid_o pulse.
- **Fairness:** ic and dc requests held continuously for 4 transactions → grants alternate D, I, D, I; no requester waits more than one other transaction.
- **Unaligned address:** dc_addr_i=0x0000_507C → mem_addr_o=0x0000_5040.
- **Timeout:** TIMEOUT=8, mem_ready_i never asserted → err_o=1 on the 8th WAIT cycle and stays 1; mem_req_o stays 1.
- **Reset mid-WAIT:** rst_n_i=0 for one cycle while in WAIT → next cycle mem_req_o=0, err_o=0, no pulses; request still held → new mem_req_o 2 cycles after reset release.
